// File: rtl/demux_scan_seq.sv
// Scans the select bus of a 3-to-8 demux over the enabled channels, pulsing din_out per channel.
// Latency: one cycle from start to the first DRIVE cycle. A break-before-make gap separates channels.
// No backpressure: start is level-sampled in IDLE, and stop aborts the scan on the next edge.
module demux_scan_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4,
    parameter int PASS_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode_cont,
    input  logic [2**SEL_W-1:0]   ch_mask,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  din_out,
    output logic                  busy,
    output logic                  done,
    output logic [PASS_W-1:0]     pass_cnt
);

    localparam int NCH = 2**SEL_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [NCH-1:0]     mask_q;
    logic               mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;

    logic [DWELL_W-1:0] dwell_eff;
    logic [SEL_W:0]     first_in;
    logic [SEL_W:0]     next_up;
    logic [SEL_W:0]     first_q;

    // Returns {found, channel}: lowest set bit of m at index lo or above.
    function automatic logic [SEL_W:0] find_from(input logic [NCH-1:0] m, input int lo);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i >= lo)) begin
                res = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    always_comb begin
        dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
        first_in  = find_from(ch_mask, 0);
        first_q   = find_from(mask_q, 0);
        next_up   = find_from(mask_q, int'(sel_out) + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mask_q   <= '0;
            mode_q   <= 1'b0;
            dwell_q  <= '0;
            cnt      <= '0;
            sel_out  <= '0;
            din_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (start && !stop) begin
                mask_q   <= ch_mask;
                mode_q   <= mode_cont;
                dwell_q  <= dwell_eff;
                pass_cnt <= '0;
                busy     <= 1'b1;
                if (ch_mask == '0) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state   <= S_DRIVE;
                    sel_out <= first_in[SEL_W-1:0];
                    din_out <= 1'b1;
                    cnt     <= dwell_eff;
                end
            end
        end else if (stop) begin
            // Abort: drop the data line immediately, keep sel_out and pass_cnt
            state   <= S_IDLE;
            din_out <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_DRIVE: begin
                    if (cnt == DWELL_W'(1)) begin
                        din_out <= 1'b0;
                        if (next_up[SEL_W]) begin
                            state <= S_GAP;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                            if (mode_q) begin
                                state <= S_GAP;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    // sel_out still holds the old channel, so the search above it is repeated here
                    state   <= S_DRIVE;
                    sel_out <= next_up[SEL_W] ? next_up[SEL_W-1:0] : first_q[SEL_W-1:0];
                    din_out <= 1'b1;
                    cnt     <= dwell_q;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scan_seq.sv
// Scoreboard bench for demux_scan_seq: expected per-cycle outputs are queued at start and compared each cycle.
module tb_demux_scan_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode_cont;
    logic [7:0] ch_mask;
    logic [3:0] dwell;
    logic [2:0] sel_out;
    logic       din_out;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;
    logic [2:0]  last_sel;
    logic [2:0]  prev_sel;
    logic        prev_din;
    bit          hold_start;

    wire [13:0] obs_vec = {sel_out, din_out, done, busy, pass_cnt};

    demux_scan_seq #(.SEL_W(3), .DWELL_W(4), .PASS_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .sel_out   (sel_out),
        .din_out   (din_out),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Vector layout: {sel[2:0], din, done, busy, pass[7:0]}
    task automatic push_exp(input logic [2:0] s, input logic d, input logic dn,
                            input logic b, input logic [7:0] p);
        exp_q.push_back({s, d, dn, b, p});
        last_sel = s;
    endtask

    task automatic gen(input logic [7:0] m, input logic [3:0] dw, input bit cont, input int ncyc);
        int         chs[$];
        int         n;
        int         dwe;
        logic [7:0] p;
        bit         fin;
        n   = 0;
        p   = 8'd0;
        fin = 1'b0;
        dwe = (dw == 4'd0) ? 1 : int'(dw);
        for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
        if (chs.size() == 0) begin
            push_exp(last_sel, 1'b0, 1'b1, 1'b1, 8'd0);
            push_exp(last_sel, 1'b0, 1'b0, 1'b0, 8'd0);
            push_exp(last_sel, 1'b0, 1'b0, 1'b0, 8'd0);
        end else begin
            while (!fin) begin
                for (int k = 0; k < chs.size(); k++) begin
                    for (int d = 0; d < dwe; d++) push_exp(3'(chs[k]), 1'b1, 1'b0, 1'b1, p);
                    n += dwe;
                    if (k < chs.size() - 1) begin
                        push_exp(3'(chs[k]), 1'b0, 1'b0, 1'b1, p);
                        n++;
                    end else begin
                        p++;
                        if (cont) begin
                            push_exp(3'(chs[k]), 1'b0, 1'b0, 1'b1, p);
                            n++;
                            if (n >= ncyc) fin = 1'b1;
                        end else begin
                            push_exp(3'(chs[k]), 1'b0, 1'b1, 1'b1, p);
                            push_exp(3'(chs[k]), 1'b0, 1'b0, 1'b0, p);
                            push_exp(3'(chs[k]), 1'b0, 1'b0, 1'b0, p);
                            fin = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_scan(input logic [7:0] m, input logic [3:0] dw, input bit cont, input int ncyc);
        ch_mask   = m;
        dwell     = dw;
        mode_cont = cont;
        start     = 1'b1;
        gen(m, dw, cont, ncyc);
    endtask

    task automatic compare_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            last_exp = exp_q.pop_front();
            check_val("cycle", obs_vec, last_exp);
            if (prev_din && din_out) check_val("sel_stable", sel_out, prev_sel);
            prev_din = din_out;
            prev_sel = sel_out;
            start    = hold_start;
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_exp(last_exp[13:11], 1'b0, 1'b0, 1'b0, last_exp[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        ch_mask = 8'h00; dwell = 4'd0; hold_start = 1'b0;
        prev_din = 1'b0; prev_sel = 3'd0; last_sel = 3'd0; last_exp = '0;
        repeat (2) @(negedge clk);
        check_val("reset_state", obs_vec, 14'd0);
        rst_n = 1'b1;

        // Reset in the middle of DRIVE on channel 3
        start_scan(8'hFF, 4'd4, 1'b0, 0);
        compare_cycles(16);
        check_val("pre_reset_sel", sel_out, 3'd3);
        rst_n = 1'b0;
        #1;
        check_val("async_reset", obs_vec, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        last_exp = '0;
        prev_din = 1'b0;
        push_idle(3);
        compare_cycles(3);
        start_scan(8'b0001_0100, 4'd1, 1'b0, 0);
        compare_cycles(exp_q.size());

        // One-shot, all channels, dwell 2
        start_scan(8'hFF, 4'd2, 1'b0, 0);
        compare_cycles(exp_q.size());
        check_val("pass_after_full", pass_cnt, 8'd1);

        // One-shot sparse mask, dwell 0 behaves as 1
        start_scan(8'b1010_0100, 4'd0, 1'b0, 0);
        compare_cycles(exp_q.size());

        // Continuous single channel, then stop mid-DRIVE
        start_scan(8'h01, 4'd3, 1'b1, 10);
        compare_cycles(10);
        stop = 1'b1;
        exp_q.delete();
        push_idle(4);
        compare_cycles(1);
        stop = 1'b0;
        compare_cycles(3);
        check_val("stop_pass_hold", pass_cnt, 8'd2);

        // Empty mask: one-cycle busy/done
        start_scan(8'h00, 4'd5, 1'b0, 0);
        compare_cycles(exp_q.size());

        // start and stop together in IDLE: nothing starts
        ch_mask = 8'hFF;
        start = 1'b1;
        stop = 1'b1;
        hold_start = 1'b1;
        push_idle(3);
        compare_cycles(3);
        hold_start = 1'b0;
        start = 1'b0;
        stop = 1'b0;

        // Continuous on channel 7: pass_cnt wrap, start and mask changes while busy
        start_scan(8'h80, 4'd1, 1'b1, 520);
        compare_cycles(100);
        hold_start = 1'b1;
        ch_mask = 8'h01;
        dwell = 4'd5;
        mode_cont = 1'b0;
        compare_cycles(5);
        hold_start = 1'b0;
        compare_cycles(415);
        check_val("pass_wrap", pass_cnt, 8'd4);
        stop = 1'b1;
        exp_q.delete();
        push_idle(2);
        compare_cycles(1);
        stop = 1'b0;
        compare_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
